// File: rtl/ring_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package ring_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RUN    = 3'd2,
    HALT   = 3'd3,
    RESULT = 3'd4
  } state_t;

  localparam int SAT_VAL    = 3000;
  localparam int NUM_MODES  = 4;
  localparam int SETTLE_DEF = 4;

endpackage

// File: rtl/ring_gate_timer.sv
// Loadable down-counter; o_done pulses for one cycle on the last cycle of a
// loaded interval (load value N-1 gives an N-cycle interval).
module ring_gate_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  // Count down from the loaded value; a new load overrides an expiring interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= i_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) r_active <= 1'b0;
      else             r_cnt    <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_active && (r_cnt == '0);

endmodule

// File: rtl/ring_meas_ctrl.sv
// System-clock sequencer for the ring-oscillator worker: ARM (reset held,
// oscillator on), RUN (gate window), HALT (oscillator off, count settles),
// RESULT (valid/ready handshake), with optional sweep of all four modes.
module ring_meas_ctrl
  import ring_pkg::*;
#(
  parameter int GATE_W  = 16,
  parameter int SETTLE  = ring_pkg::SETTLE_DEF,
  parameter int DATA_W  = 12,
  parameter int SAT_VAL = ring_pkg::SAT_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              scan,
  input  logic [1:0]        mode_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] raw_data,
  output logic              ring_en,
  output logic              worker_reset,
  output logic [1:0]        mode,
  output logic              busy,
  output logic [DATA_W-1:0] result_data,
  output logic [1:0]        result_mode,
  output logic              result_sat,
  output logic              result_valid,
  input  logic              result_ready
);

  state_t              r_state;
  logic [GATE_W-1:0]   r_gate;
  logic                r_scan;
  logic [1:0]          r_mode;
  logic                r_ring_en;
  logic                r_worker_reset;
  logic                r_busy;
  logic [DATA_W-1:0]   r_res_data;
  logic [1:0]          r_res_mode;
  logic                r_res_sat;
  logic                r_res_valid;

  logic                w_done;
  logic                w_load;
  logic [GATE_W-1:0]   w_load_val;
  logic                w_hs;
  logic                w_more;

  assign w_hs   = r_res_valid && result_ready;
  assign w_more = r_scan && (r_mode != 2'(NUM_MODES - 1));

  // Reload the shared timer on every transition into ARM, RUN or HALT.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    if (!abort) begin
      case (r_state)
        IDLE: if (start) begin
          w_load     = 1'b1;
          w_load_val = GATE_W'(SETTLE - 1);
        end
        ARM: if (w_done) begin
          w_load     = 1'b1;
          w_load_val = r_gate - 1'b1;
        end
        RUN: if (w_done) begin
          w_load     = 1'b1;
          w_load_val = GATE_W'(SETTLE - 1);
        end
        RESULT: if (w_hs && w_more) begin
          w_load     = 1'b1;
          w_load_val = GATE_W'(SETTLE - 1);
        end
        default: ;
      endcase
    end
  end

  ring_gate_timer #(
    .CNT_W (GATE_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );

  // Measurement FSM; every output is set together with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_gate         <= GATE_W'(1);
      r_scan         <= 1'b0;
      r_mode         <= 2'd0;
      r_ring_en      <= 1'b0;
      r_worker_reset <= 1'b1;
      r_busy         <= 1'b0;
      r_res_data     <= '0;
      r_res_mode     <= 2'd0;
      r_res_sat      <= 1'b0;
      r_res_valid    <= 1'b0;
    end else if (abort) begin
      // Result registers deliberately keep their last value.
      r_state        <= IDLE;
      r_ring_en      <= 1'b0;
      r_worker_reset <= 1'b1;
      r_busy         <= 1'b0;
      r_res_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_gate         <= (gate_len == '0) ? GATE_W'(1) : gate_len;
          r_scan         <= scan;
          r_mode         <= scan ? 2'd0 : mode_sel;
          r_state        <= ARM;
          r_ring_en      <= 1'b1;
          r_worker_reset <= 1'b1;
          r_busy         <= 1'b1;
        end
        ARM: if (w_done) begin
          r_state        <= RUN;
          r_worker_reset <= 1'b0;
        end
        RUN: if (w_done) begin
          r_state   <= HALT;
          r_ring_en <= 1'b0;
        end
        HALT: if (w_done) begin
          r_state        <= RESULT;
          r_worker_reset <= 1'b1;
          r_res_data     <= raw_data;
          r_res_sat      <= (raw_data == DATA_W'(SAT_VAL));
          r_res_mode     <= r_mode;
          r_res_valid    <= 1'b1;
        end
        RESULT: if (w_hs) begin
          r_res_valid <= 1'b0;
          if (w_more) begin
            r_mode    <= r_mode + 2'd1;
            r_state   <= ARM;
            r_ring_en <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_ring_en      <= 1'b0;
          r_worker_reset <= 1'b1;
          r_busy         <= 1'b0;
          r_res_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign ring_en      = r_ring_en;
  assign worker_reset = r_worker_reset;
  assign mode         = r_mode;
  assign busy         = r_busy;
  assign result_data  = r_res_data;
  assign result_mode  = r_res_mode;
  assign result_sat   = r_res_sat;
  assign result_valid = r_res_valid;

endmodule

// File: doc/ring_meas_ctrl.md
Name: ring_meas_ctrl

Overview:
- System-clock-domain sequencer for the ring-oscillator worker.
- Each measurement runs in order:
  - holds the worker in reset with the oscillator running;
  - opens a programmable gate window;
  - stops the oscillator so the worker count freezes;
  - waits for the frozen count to settle, then captures it;
  - presents the result on a valid/ready handshake.
- Optionally scans all four oscillator modes back-to-back.
- Sits between the register/control interface and the worker instance.

Parameters:
- GATE_W, 16, width of the gate-length counter and input.
- SETTLE, 4, system cycles spent in ARM and in HALT (≥2).
- DATA_W, 12, width of the worker count.
- SAT_VAL, 3000, worker saturation value; a count equal to it flags saturation.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a run when idle, ignored otherwise.
- scan  in  1  sampled at start; 1 = sweep modes 0..3, 0 = single measurement.
- mode_sel  in  2  mode for a single run; ignored when scan=1.
- gate_len  in  GATE_W  gate window in clk cycles, sampled at start; 0 is treated as 1.
- abort  in  1  level; forces return to IDLE from any state.
- raw_data  in  DATA_W  worker count; stable only while ring_en=0.
- ring_en  out  1  oscillator enable.
- worker_reset  out  1  active-high reset to the worker.
- mode  out  2  mode to the oscillator/worker.
- busy  out  1  high in every state except IDLE.
- result_data  out  DATA_W  captured count.
- result_mode  out  2  mode the result belongs to.
- result_sat  out  1  captured count == SAT_VAL.
- result_valid  out  1  result handshake valid.
- result_ready  in  1  result handshake ready.

Behaviour:
- Reset values:
  - state=IDLE, ring_en=0, worker_reset=1, mode=0, busy=0;
  - result_data=0, result_mode=0, result_sat=0, result_valid=0.
- Every output is registered; no combinational path from inputs to outputs.
- IDLE:
  - ring_en=0, worker_reset=1.
  - On start: latch gate_len (0→1) and scan; mode ← scan ? 0 : mode_sel; go to ARM.
- ARM:
  - ring_en=1, worker_reset=1 for exactly SETTLE cycles, so the worker's reset synchroniser sees oscillator edges.
  - Then go to RUN.
- RUN:
  - ring_en=1, worker_reset=0 for exactly the latched gate_len cycles; the down-counter is loaded on entry.
  - Then go to HALT.
- HALT:
  - ring_en=0, worker_reset=0 for SETTLE cycles.
  - raw_data is sampled into result_data on the last HALT cycle.
  - result_sat and result_mode are set in the same cycle.
  - Then go to RESULT.
- RESULT:
  - result_valid=1, ring_en=0; worker_reset returns to 1.
  - result_data, result_mode and result_sat are held stable until the cycle with result_valid & result_ready.
  - On that handshake, result_valid falls the next cycle.
  - If scan and mode<3: mode ← mode+1, go to ARM.
  - Otherwise go to IDLE.
  - No wrap: scan finishes after mode 3.
- Backpressure: the controller stalls in RESULT indefinitely, with the oscillator off.
- abort:
  - Takes priority over every transition.
  - Next state is IDLE; result_valid clears; result registers keep their last value.
- start while busy: ignored.
- start and abort in the same cycle: abort wins, and the block stays in IDLE.
- gate_len up to 2^GATE_W−1 is legal; no other boundaries.
- rst_n asserted mid-run: all state returns to reset values immediately (asynchronously); the oscillator stops.
- mode changes only in IDLE→ARM and RESULT→ARM, i.e. only while worker_reset=1.

Decomposition:
- Shared package ring_pkg:
  - state enum: IDLE, ARM, RUN, HALT, RESULT;
  - constants SAT_VAL, NUM_MODES=4, default SETTLE.
- One natural sub-module, ring_gate_timer: a loadable down-counter with a done pulse, reused for the ARM, RUN and HALT durations.

Test Plan:
- Single run:
  - Stimulus: scan=0, mode_sel=2, gate_len=10, start; raw_data model counts while ring_en=1.
  - Response: mode=2; worker_reset=0 for exactly 10 cycles; ring_en=0 for 4 cycles; result_valid=1, result_mode=2, result_data equals the model's frozen count.
- Saturation:
  - Stimulus: gate_len=5000 with a model that saturates at 3000.
  - Response: result_data=3000, result_sat=1.
- Scan with backpressure:
  - Stimulus: scan=1, gate_len=3, result_ready held low 7 cycles per result.
  - Response: four results with result_mode 0,1,2,3 in order; data stable while stalled; busy falls after the 4th handshake.
- gate_len=0:
  - Response: RUN lasts exactly 1 cycle.
- Abort and ignored start:
  - Stimulus: abort in RUN, then start during ARM of a new run.
  - Response: IDLE next cycle, ring_en=0, worker_reset=1, result_valid=0; the second start is ignored.
- Asynchronous reset:
  - Stimulus: rst_n low mid-HALT, between clock edges.
  - Response: all outputs at reset values before the next clk edge.
